// File: rtl/sha256_arbiter.sv
// Two-port round-robin front end for a SHA-256 core. It locks one port for a whole message, sequences init/next, and returns the digest.
// Optional WAIT watchdog is compiled in with `define SHA256_ARB_WDOG_EN.
module sha256_arbiter #(
  parameter logic [7:0] WDOG_LIMIT = 8'd100
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_last,
  input  logic [511:0] req0_block,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_last,
  input  logic [511:0] req1_block,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [255:0] resp_digest,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic         core_digest_valid,
  input  logic [255:0] core_digest,
  output logic         busy,
  output logic         wdog_err
);

  typedef enum logic [2:0] {ARB, ISSUE, WAIT, NEXT, RESP} state_t;

  state_t       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         owner_q, owner_d;
  logic         last_q, last_d;
  logic         first_q, first_d;
  logic [511:0] blk_q, blk_d;
  logic [255:0] digest_q, digest_d;

  logic [1:0]   valid;
  logic [1:0]   ready;
  logic         gnt_any, gnt_port;
  logic         sel_port;
  logic [511:0] sel_block;
  logic         sel_last;
  logic         wdog_hit;
  logic         wdog_fire;

  assign valid = {req1_valid, req0_valid};

  // Round-robin: the pointer port wins a tie, otherwise whichever port is offering.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = ptr_q;
    if (valid[ptr_q]) begin
      gnt_any  = 1'b1;
      gnt_port = ptr_q;
    end else if (valid[~ptr_q]) begin
      gnt_any  = 1'b1;
      gnt_port = ~ptr_q;
    end
  end

  // While a message is in flight only its owner may supply further blocks.
  assign sel_port  = (state_q == NEXT) ? owner_q : gnt_port;
  assign sel_block = sel_port ? req1_block : req0_block;
  assign sel_last  = sel_port ? req1_last  : req0_last;

`ifdef SHA256_ARB_WDOG_EN
  logic [7:0] wdog_cnt_q;

  assign wdog_hit = (state_q == WAIT) && (wdog_cnt_q == WDOG_LIMIT);

  // Counts cycles spent in WAIT; held at zero elsewhere so every WAIT entry starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= '0;
    end else if (state_q != WAIT) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_q + 8'd1;
    end
  end
`else
  logic unused_wdog_limit;

  assign wdog_hit          = 1'b0;
  assign unused_wdog_limit = ^WDOG_LIMIT;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    last_d    = last_q;
    first_d   = first_q;
    blk_d     = blk_q;
    digest_d  = digest_q;
    ready     = 2'b00;
    core_init = 1'b0;
    core_next = 1'b0;
    wdog_fire = 1'b0;

    case (state_q)
      ARB: begin
        if (gnt_any) begin
          ready[gnt_port] = 1'b1;
          owner_d         = gnt_port;
          blk_d           = sel_block;
          last_d          = sel_last;
          first_d         = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (core_ready) begin
          core_init = first_q;
          core_next = !first_q;
          first_d   = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (core_ready && core_digest_valid) begin
          if (last_q) begin
            digest_d = core_digest;
            state_d  = RESP;
          end else begin
            state_d  = NEXT;
          end
        end else if (wdog_hit) begin
          // Abort: drop the lock and give the other port the next turn.
          wdog_fire = 1'b1;
          ptr_d     = ~owner_q;
          state_d   = ARB;
        end
      end
      NEXT: begin
        if (valid[owner_q]) begin
          ready[owner_q] = 1'b1;
          blk_d          = sel_block;
          last_d         = sel_last;
          state_d        = ISSUE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          ptr_d   = ~owner_q;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
      first_q  <= 1'b0;
      // NOTE: the wide block and digest are plain flops, not RAM, so resetting them is cheap and keeps outputs clean in reset.
      blk_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      first_q  <= first_d;
      blk_q    <= blk_d;
      digest_q <= digest_d;
    end
  end

  assign req0_ready  = ready[0];
  assign req1_ready  = ready[1];
  assign resp_valid  = (state_q == RESP);
  assign resp_id     = owner_q;
  assign resp_digest = digest_q;
  assign core_block  = blk_q;
  assign busy        = (state_q != ARB);
  assign wdog_err    = wdog_fire;

  a_pulse_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
    !(core_init && core_next));
  a_pulse_in_issue : assert property (@(posedge clk) disable iff (!reset_n)
    (core_init || core_next) |-> (state_q == ISSUE));
  a_block_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == WAIT) |-> $stable(blk_q));
  a_resp_hold : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == RESP && !resp_ready) |=> (state_q == RESP && $stable(digest_q) && $stable(owner_q)));

endmodule
